clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised bank of independent programmable clock-enable generators. It replaces fixed-ratio dividers with NUM_CH channels, each with a runtime-programmable divisor and per-channel enable. Each channel emits a one-cycle tick pulse and an optional square-wave level. It sits directly after the 100 MHz master clock and feeds the display-refresh, counting and blink logic of the stopwatch/clock designs.

## Interface
- NUM_CH, 4: number of channels (≥1)
- CNT_W, 27: counter/divisor width
- DIV_RST, 50_000_000: divisor loaded into every channel at reset (must fit CNT_W)

- clk_100MHz  in  1  master clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ch_en  in  NUM_CH  per-channel run enable
- sync_clr  in  1  restart all channels phase-aligned
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  divisor write slot free
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_div  in  CNT_W  new divisor D
- tick  out  NUM_CH  one-cycle pulse every D enabled cycles
- clk_out  out  NUM_CH  toggles on each tick (period 2·D)

## Operation
- Reset: counters 0, divisors DIV_RST, tick 0, clk_out 0, pending slot empty, cfg_ready 1.
- Per channel i, each edge with ch_en[i]=1 and D≥1: if cnt==D-1 then cnt←0, tick[i]←1, clk_out[i]←~clk_out[i]; else cnt←cnt+1, tick[i]←0.
- Counting from the first enabled edge (cnt=0), tick is high after edges D, 2D, 3D…
- D=1: tick held high continuously; clk_out toggles every cycle.
- D=0: channel parked: cnt held at 0, tick 0, clk_out holds.
- ch_en[i]=0: cnt and clk_out hold, tick[i]←0. Re-enable resumes from the held count.
- Config handshake: a transfer occurs on an edge with cfg_valid && cfg_ready. There is a single pending slot, and cfg_ready=0 while it is occupied. cfg_valid may be held; cfg_* must remain stable until the transfer.
- Pending update applies glitch-free at the target channel's next wrap edge (cnt==D_old-1). That edge ticks normally, then D←D_new with cnt←0. The next tick follows D_new edges later.
- If the target channel is disabled or has D_old=0, the update applies on the edge after acceptance.
- cfg_ch ≥ NUM_CH: accepted, discarded; cfg_ready stays 1.
- sync_clr=1 on an edge (priority over wrap and enable): all cnt←0, tick←0, clk_out←0. Any pending update is applied immediately. A transfer accepted on the same edge is also applied immediately.
- rst_n low mid-operation: immediate return to reset values; pending update is lost.

## Timing
- tick and clk_out are registered, with no combinational path from inputs.
- Divisor applies at the wrap edge; the first tick at the new rate occurs D_new edges later.
- cfg_ready returns to 1 in the cycle after the apply edge. Minimum back-to-back throughput is one transfer per 2 cycles.
- Reset assertion is asynchronous. Deassertion is assumed synchronised upstream, and the first counting edge is the first edge with rst_n high.

## Configuration
- CLK_DIV_BANK_SQUARE_EN defined: clk_out toggle flops present, behaviour as above.
- Not defined: clk_out tied to 0 and toggle flops removed; tick behaviour unchanged.

## Structure
- Package clk_div_pkg: default CNT_W and DIV_RST constants, typedef of the divisor/counter vector, cfg-channel width function.
- Sub-module clk_div_chan: one channel (counter, divisor register, tick/clk_out flops, apply input). Instantiated NUM_CH times by generate. Pending slot and handshake stay in the top level.

## Test plan
Bench parameters: NUM_CH=4, CNT_W=8, DIV_RST=4.
- Release reset, ch_en=4'b0001 -> tick[0] high after edges 4, 8, 12; clk_out[0] = 1, 0, 1 at those edges; channels 1–3 stay 0.
- ch_en=4'b0010; at cnt[1]=2 write ch1 D=3 -> cfg_ready 0 until wrap. Tick at edge 4 (old rate), then ticks 3 apart; cfg_ready 1 the cycle after wrap.
- Write D=1 to ch2 -> tick[2] constant 1, clk_out[2] toggles every cycle. Write D=0 -> tick[2] 0, clk_out[2] frozen.
- ch0 D=4, ch1 D=6, both enabled; assert sync_clr mid-count -> all tick/clk_out 0. Ticks then occur 4 and 6 edges after clear, in phase; common tick at edge 12.
- ch0 enabled, drop ch_en[0] at cnt=2 for 5 cycles, re-enable -> no ticks while disabled; tick 2 edges after re-enable.
- Pending write to ch3 (D=7), then assert rst_n low before wrap -> outputs 0 immediately, cfg_ready 1. After release, ch3 ticks every 4, not 7.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the clk_div_bank clock-enable generator bank.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 27;
  localparam int DIV_RST_DEF = 50_000_000;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int cfg_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable clock-enable channel: counter, divisor register and tick/clk_out flops.
// clk_out toggle flop only exists when CLK_DIV_BANK_SQUARE_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             upd_valid,
  input  logic [CNT_W-1:0] upd_div,
  output logic             upd_taken,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             parked;
  logic             wrap;

  assign parked = (div == '0);
  assign wrap   = !parked && (cnt == div - 1'b1);

  // A new divisor lands only where it cannot shorten or stretch a running period.
  assign upd_taken = upd_valid && (sync_clr || !en || parked || wrap);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      div  <= CNT_W'(DIV_RST);
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync_clr || upd_taken || (en && wrap)) begin
        cnt <= '0;
      end else if (en && !parked) begin
        cnt <= cnt + 1'b1;
      end
      if (en && wrap && !sync_clr) begin
        tick <= 1'b1;
      end
      if (upd_taken) begin
        div <= upd_div;
      end
    end
  end

`ifdef CLK_DIV_BANK_SQUARE_EN
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      clk_out <= 1'b0;
    end else if (sync_clr) begin
      clk_out <= 1'b0;
    end else if (en && wrap) begin
      clk_out <= ~clk_out;
    end
  end
`else
  assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock-enable generators with a single-slot divisor update port.
// Define CLK_DIV_BANK_SQUARE_EN to build the per-channel square-wave clk_out flops.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  CNT_W   = CNT_W_DEF,
  parameter int  DIV_RST = DIV_RST_DEF,
  localparam int CH_W    = cfg_ch_w(NUM_CH)
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_div;
  logic              xfer;
  logic              ch_ok;
  logic [NUM_CH-1:0] upd_valid;
  logic [NUM_CH-1:0] upd_taken;
  logic [CNT_W-1:0]  upd_div;

  assign cfg_ready = !pend_valid;
  assign xfer      = cfg_valid && cfg_ready;
  assign ch_ok     = (int'(cfg_ch) < NUM_CH);
  assign upd_div   = pend_valid ? pend_div : cfg_div;

  // Writes to a nonexistent channel, or ones landing on a sync_clr edge, never occupy the slot.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else if (pend_valid) begin
      if (|upd_taken) begin
        pend_valid <= 1'b0;
      end
    end else if (xfer && ch_ok && !sync_clr) begin
      pend_valid <= 1'b1;
      pend_ch    <= cfg_ch;
      pend_div   <= cfg_div;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign upd_valid[i] = pend_valid ? (pend_ch == CH_W'(i))
                                     : (sync_clr && xfer && ch_ok && (cfg_ch == CH_W'(i)));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_100MHz (clk_100MHz),
      .rst_n      (rst_n),
      .en         (ch_en[i]),
      .sync_clr   (sync_clr),
      .upd_valid  (upd_valid[i]),
      .upd_div    (upd_div),
      .upd_taken  (upd_taken[i]),
      .tick       (tick[i]),
      .clk_out    (clk_out[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed, table-driven bench for clk_div_bank (NUM_CH=4, CNT_W=8, DIV_RST=4).
module tb_clk_div_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int DIV_RST = 4;

`ifdef CLK_DIV_BANK_SQUARE_EN
  localparam logic [3:0] SQ_MASK = 4'hF;
`else
  localparam logic [3:0] SQ_MASK = 4'h0;
`endif

  logic       clk_100MHz = 1'b0;
  logic       rst_n      = 1'b0;
  logic [3:0] ch_en      = '0;
  logic       sync_clr   = 1'b0;
  logic       cfg_valid  = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch     = '0;
  logic [7:0] cfg_div    = '0;
  logic [3:0] tick;
  logic [3:0] clk_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         do_rst;
    logic [3:0] en;
    logic       sclr;
    logic       cv;
    logic [1:0] cch;
    logic [7:0] cdiv;
    logic [3:0] tk;
    logic [3:0] ck;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_100MHz = ~clk_100MHz;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .sync_clr   (sync_clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .tick       (tick),
    .clk_out    (clk_out)
  );

  function automatic vec_t mk(input bit rst, input logic [3:0] en, input logic sclr, input logic cv,
                              input logic [1:0] cch, input logic [7:0] cdiv,
                              input logic [3:0] tk, input logic [3:0] ck, input logic rdy);
    vec_t v;
    v.do_rst = rst; v.en = en; v.sclr = sclr; v.cv = cv; v.cch = cch; v.cdiv = cdiv;
    v.tk = tk; v.ck = ck; v.rdy = rdy;
    return v;
  endfunction

  task automatic applyStimulus(input logic [3:0] en, input logic sclr, input logic cv,
                               input logic [1:0] cch, input logic [7:0] cdiv);
    ch_en     = en;
    sync_clr  = sclr;
    cfg_valid = cv;
    cfg_ch    = cch;
    cfg_div   = cdiv;
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] tk, input logic [3:0] ck, input logic rdy);
    logic [3:0] ck_exp;
    ck_exp = ck & SQ_MASK;
    checks += 3;
    if (tick !== tk) begin
      failures++;
      $display("[TB] FAIL %s tick got=%b exp=%b", name, tick, tk);
    end
    if (clk_out !== ck_exp) begin
      failures++;
      $display("[TB] FAIL %s clk_out got=%b exp=%b", name, clk_out, ck_exp);
    end
    if (cfg_ready !== rdy) begin
      failures++;
      $display("[TB] FAIL %s cfg_ready got=%b exp=%b", name, cfg_ready, rdy);
    end
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    ch_en     = '0;
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    @(negedge clk_100MHz);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Free-running ch0 at the reset divisor: ticks on edges 4, 8, 12.
    vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1));
    // ch1 rewritten to D=3 at cnt=2: old-rate tick on edge 4, then edges 7, 10.
    vecs.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 1, 3, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010, 1));
    // ch2: D=1 gives a constant tick, then D=0 parks it with clk_out frozen.
    vecs.push_back(mk(1, 4'b0100, 0, 1, 2, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 2, 0, 4'b0100, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0100, 1));
    // sync_clr on edge 6 with a same-edge ch1 D=6 write: ticks 4 and 6 edges later, joint tick at +12.
    vecs.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0011, 4'b0011, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0011, 1));
    vecs.push_back(mk(0, 4'b0011, 1, 1, 1, 6, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0010, 4'b0011, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0011, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0001, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0000, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 4'b0011, 4'b0001, 1));
    // ch0 disabled at cnt=2 for 5 edges: count holds, tick on the 2nd edge after re-enable.
    vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 1));

    #2;
    checkOutput("reset", 4'b0000, 4'b0000, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) doReset();
      applyStimulus(vecs[i].en, vecs[i].sclr, vecs[i].cv, vecs[i].cch, vecs[i].cdiv);
      checkOutput($sformatf("row%0d", i), vecs[i].tk, vecs[i].ck, vecs[i].rdy);
    end

    // Pending ch3 write lost to an asynchronous reset; ch3 keeps the reset divisor afterwards.
    doReset();
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(4'b1000, 1'b0, 1'b0, 2'd0, 8'd0);
      checkOutput($sformatf("pre_rst_e%0d", e), (e == 4) ? 4'b1000 : 4'b0000,
                  (e == 4) ? 4'b1000 : 4'b0000, 1'b1);
    end
    applyStimulus(4'b1000, 1'b0, 1'b1, 2'd3, 8'd7);
    checkOutput("pend_accept", 4'b0000, 4'b1000, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("pend_hold", 4'b0000, 4'b1000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 4'b0000, 4'b0000, 1'b1);
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(4'b1000, 1'b0, 1'b0, 2'd0, 8'd0);
      checkOutput($sformatf("post_rst_e%0d", e), (e % 4 == 0) ? 4'b1000 : 4'b0000,
                  (e >= 4 && e <= 7) ? 4'b1000 : 4'b0000, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
